ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
//  Parametrised successor to the fixed ROMulator enable/mux glue. Owns the single RAM port and hands it to the
//  flash loader (boot), the CPU bus (run) or the diagnostics engine (halt). Adds:
//  - a synchronised phi2 edge detector;
//  - N configurable address regions with per-region write-protect;
//  - a safe halt request/acknowledge handshake;
//  - a saturating count of blocked writes.
//  Sits between sram64k, spi_flash_reader, diagnostics and the CPU pins.
// PARAMETERS
//  ADDR_WIDTH   16  CPU/RAM address width
//  DATA_WIDTH   8   data bus width
//  NUM_REGIONS  4   number of decoded regions (1..8)
//  SYNC_STAGES  2   flops in phi2/rwbar/address-valid synchroniser (>=2)
//  VIOL_WIDTH   8   width of write-violation counter
// PORTS
//  clk            in   1            system clock (SB_HFOSC domain)
//  reset          in   1            asynchronous, active-high reset
//  address        in   ADDR_WIDTH   CPU address bus
//  phi2           in   1            CPU phase-2 clock (asynchronous to clk)
//  rwbar          in   1            CPU read(1)/write(0)
//  cpu_data_in    in   DATA_WIDTH   data captured from CPU bus
//  ld_address     in   ADDR_WIDTH   flash loader address
//  ld_data        in   DATA_WIDTH   flash loader write data
//  ld_cs, ld_we   in   1            flash loader strobes
//  ld_done        in   1            loader finished (level, stays high)
//  diag_halt_req  in   1            diagnostics requests CPU halt (level)
//  diag_address   in   ADDR_WIDTH   diagnostics address
//  diag_data      in   DATA_WIDTH   diagnostics write data
//  diag_cs, diag_we in 1            diagnostics strobes
//  region_base    in   NUM_REGIONS*ADDR_WIDTH   packed base per region
//  region_mask    in   NUM_REGIONS*ADDR_WIDTH   packed compare mask per region
//  region_en      in   NUM_REGIONS  region enable
//  region_ro      in   NUM_REGIONS  region write-protect (ROM)
//  ram_address    out  ADDR_WIDTH   to RAM
//  ram_datain     out  DATA_WIDTH   to RAM
//  ram_cs, ram_we out  1            to RAM
//  data_oe        out  1            drive CPU data pins (read hit, RUN, phi2 high)
//  dataoutenable  out  1            active-low buffer enable = !data_oe
//  busenable      out  1            active-low bus transceiver enable, low on any region hit in RUN
//  rdy            out  1            CPU RDY
//  diag_halt_ack  out  1            RAM owned by diagnostics
//  viol_count     out  VIOL_WIDTH   saturating count of blocked writes
//  state_o        out  3            current FSM state (debug)
// BEHAVIOUR
//  Reset values: state LOAD; rdy=0; diag_halt_ack=0; data_oe=0; dataoutenable=1; busenable=1;
//    ram_cs=ram_we=0; viol_count=0; synchronisers=0.
//  Synchroniser and edge detection:
//  - phi2 and rwbar pass through SYNC_STAGES flops.
//  - phi2_rise/phi2_fall are 1-clk pulses from the last two stages.
//  - address is sampled into addr_q on phi2_rise.
//  Region decode:
//  - hit[i] = region_en[i] & ((addr_q & mask[i]) == (base[i] & mask[i])).
//  - On multiple hits, the lowest index wins.
//  FSM states: LOAD, RUN, HALT_PEND, HALTED, RESUME.
//  - LOAD: RAM port <= ld_*; rdy=0. Move to RUN on ld_done.
//  - RUN: RAM port <= CPU; rdy=1.
//    - CPU read: ram_cs=1 while sync phi2 high, rwbar=1 and hit; data_oe follows the same condition.
//    - CPU write: rwbar=0 and hit at phi2_fall gives a 1-clk ram_cs+ram_we pulse with cpu_data_in.
//    - Write to a region with region_ro set: no ram_we; viol_count+1, saturating at all-ones.
//    - On diag_halt_req, go to HALT_PEND.
//  - HALT_PEND: rdy=0 immediately.
//    - CPU transactions are still served exactly as in RUN.
//    - On the first phi2_fall with sync rwbar=1 (CPU is then stalled on a read), go to HALTED.
//    - If diag_halt_req drops before then, go to RESUME.
//  - HALTED: RAM port <= diag_*; diag_halt_ack=1; data_oe=0; busenable=1; rdy=0.
//    Move to RESUME when diag_halt_req=0.
//  - RESUME: exactly 1 clk; diag_halt_ack=0, rdy=0, no RAM access. Then go to RUN.
//  Timing and boundary rules:
//  - All outputs are registered; 1-clk latency from the synchronised event.
//  - ld_done low in any state other than LOAD is ignored (no return to LOAD without reset).
//  - diag_halt_req during LOAD is held pending; it is acted on at the first RUN cycle.
//  - Reset mid-write aborts the pulse: ram_we goes 0 asynchronously.
//  - Address wrap: no special case; the mask compare covers the full ADDR_WIDTH.
// TESTING
//  1 reset; ld writes 0xA5 @0x1234; ld_done -> RAM sees ld_* only; state RUN 1 clk after ld_done; rdy=1.
//  2 region0 base 0xF000 mask 0xF000 ro=1; CPU write 0x55 @0xF800 -> no ram_we; viol_count=1; 300 more -> 0xFF.
//  3 region1 base 0x0000 mask 0x8000 rw; CPU write 0x3C @0x0010 -> single 1-clk ram_we at phi2_fall, ram_datain=0x3C.
//  4 diag_halt_req during a CPU write cycle -> rdy=0 at once; ack only after next read-cycle phi2_fall; diag_* then on RAM.
//  5 drop diag_halt_req in HALTED -> 1 RESUME clk with no ram_cs, then RUN; rdy=1; CPU read @0x0010 returns 0x3C.
//  6 regions 0 and 1 overlap at 0x0000, region0 ro -> lowest index wins: write blocked. Async reset mid-HALTED -> LOAD, ack=0.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// RAM port owner for the ROMulator: hands the single RAM port to the flash loader,
// the CPU bus or the diagnostics engine, with region decode, write-protect and halt handshake.
module ram_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned VIOL_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic                              phi2,
  input  logic                              rwbar,
  input  logic [DATA_WIDTH-1:0]             cpu_data_in,
  input  logic [ADDR_WIDTH-1:0]             ld_address,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  input  logic                              ld_cs,
  input  logic                              ld_we,
  input  logic                              ld_done,
  input  logic                              diag_halt_req,
  input  logic [ADDR_WIDTH-1:0]             diag_address,
  input  logic [DATA_WIDTH-1:0]             diag_data,
  input  logic                              diag_cs,
  input  logic                              diag_we,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_mask,
  input  logic [NUM_REGIONS-1:0]            region_en,
  input  logic [NUM_REGIONS-1:0]            region_ro,
  output logic [ADDR_WIDTH-1:0]             ram_address,
  output logic [DATA_WIDTH-1:0]             ram_datain,
  output logic                              ram_cs,
  output logic                              ram_we,
  output logic                              data_oe,
  output logic                              dataoutenable,
  output logic                              busenable,
  output logic                              rdy,
  output logic                              diag_halt_ack,
  output logic [VIOL_WIDTH-1:0]             viol_count,
  output logic [2:0]                        state_o
);

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_RUN       = 3'd1,
    ST_HALT_PEND = 3'd2,
    ST_HALTED    = 3'd3,
    ST_RESUME    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  phi2_sync_q, phi2_sync_d;
  logic [SYNC_STAGES-1:0]  rwbar_sync_q, rwbar_sync_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0]   ram_datain_q, ram_datain_d;
  logic                    ram_cs_q, ram_cs_d;
  logic                    ram_we_q, ram_we_d;
  logic                    data_oe_q, data_oe_d;
  logic                    dataoutenable_q, dataoutenable_d;
  logic                    busenable_q, busenable_d;
  logic                    rdy_q, rdy_d;
  logic                    ack_q, ack_d;
  logic [VIOL_WIDTH-1:0]   viol_q, viol_d;

  logic                    phi2_s_c, rwbar_s_c, phi2_rise_c, phi2_fall_c;
  logic [NUM_REGIONS-1:0]  hit_c;
  logic                    any_hit_c, win_ro_c;

  // Edge detection uses the last two synchroniser stages; index 0 is the newest sample.
  always_comb begin
    phi2_sync_d  = {phi2_sync_q[SYNC_STAGES-2:0], phi2};
    rwbar_sync_d = {rwbar_sync_q[SYNC_STAGES-2:0], rwbar};
    phi2_s_c     = phi2_sync_q[SYNC_STAGES-1];
    rwbar_s_c    = rwbar_sync_q[SYNC_STAGES-1];
    phi2_rise_c  = phi2_sync_q[SYNC_STAGES-2] & ~phi2_sync_q[SYNC_STAGES-1];
    phi2_fall_c  = ~phi2_sync_q[SYNC_STAGES-2] & phi2_sync_q[SYNC_STAGES-1];
    addr_d       = phi2_rise_c ? address : addr_q;
  end

  // Region decode; the descending scan leaves the lowest-index hit in win_ro_c.
  always_comb begin
    hit_c    = '0;
    win_ro_c = 1'b0;
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      hit_c[i] = region_en[i] &
                 ((addr_q & region_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                  (region_base[i*ADDR_WIDTH +: ADDR_WIDTH] & region_mask[i*ADDR_WIDTH +: ADDR_WIDTH]));
      if (hit_c[i]) win_ro_c = region_ro[i];
    end
    any_hit_c = |hit_c;
  end

  // Next state, then registered outputs decoded from the state being entered.
  always_comb begin
    state_d         = state_q;
    ram_address_d   = addr_q;
    ram_datain_d    = cpu_data_in;
    ram_cs_d        = 1'b0;
    ram_we_d        = 1'b0;
    data_oe_d       = 1'b0;
    busenable_d     = 1'b1;
    rdy_d           = 1'b0;
    ack_d           = 1'b0;
    viol_d          = viol_q;

    case (state_q)
      ST_LOAD:      if (ld_done) state_d = ST_RUN;
      ST_RUN:       if (diag_halt_req) state_d = ST_HALT_PEND;
      ST_HALT_PEND: begin
        if (!diag_halt_req)                state_d = ST_RESUME;
        else if (phi2_fall_c && rwbar_s_c) state_d = ST_HALTED;
      end
      ST_HALTED:    if (!diag_halt_req) state_d = ST_RESUME;
      ST_RESUME:    state_d = ST_RUN;
      default:      state_d = ST_LOAD;
    endcase

    case (state_d)
      ST_LOAD: begin
        ram_address_d = ld_address;
        ram_datain_d  = ld_data;
        ram_cs_d      = ld_cs;
        ram_we_d      = ld_we;
      end
      ST_RUN, ST_HALT_PEND: begin
        rdy_d       = (state_d == ST_RUN);
        busenable_d = ~any_hit_c;
        if (phi2_s_c && rwbar_s_c && any_hit_c) begin
          ram_cs_d  = 1'b1;
          data_oe_d = 1'b1;
        end
        if (phi2_fall_c && !rwbar_s_c && any_hit_c) begin
          if (win_ro_c) begin
            if (viol_q != {VIOL_WIDTH{1'b1}}) viol_d = viol_q + VIOL_WIDTH'(1);
          end else begin
            ram_cs_d = 1'b1;
            ram_we_d = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        ram_address_d = diag_address;
        ram_datain_d  = diag_data;
        ram_cs_d      = diag_cs;
        ram_we_d      = diag_we;
        ack_d         = 1'b1;
      end
      default: ;
    endcase

    dataoutenable_d = ~data_oe_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_LOAD;
      phi2_sync_q     <= '0;
      rwbar_sync_q    <= '0;
      addr_q          <= '0;
      ram_address_q   <= '0;
      ram_datain_q    <= '0;
      ram_cs_q        <= 1'b0;
      ram_we_q        <= 1'b0;
      data_oe_q       <= 1'b0;
      dataoutenable_q <= 1'b1;
      busenable_q     <= 1'b1;
      rdy_q           <= 1'b0;
      ack_q           <= 1'b0;
      viol_q          <= '0;
    end else begin
      state_q         <= state_d;
      phi2_sync_q     <= phi2_sync_d;
      rwbar_sync_q    <= rwbar_sync_d;
      addr_q          <= addr_d;
      ram_address_q   <= ram_address_d;
      ram_datain_q    <= ram_datain_d;
      ram_cs_q        <= ram_cs_d;
      ram_we_q        <= ram_we_d;
      data_oe_q       <= data_oe_d;
      dataoutenable_q <= dataoutenable_d;
      busenable_q     <= busenable_d;
      rdy_q           <= rdy_d;
      ack_q           <= ack_d;
      viol_q          <= viol_d;
    end
  end

  assign ram_address   = ram_address_q;
  assign ram_datain    = ram_datain_q;
  assign ram_cs        = ram_cs_q;
  assign ram_we        = ram_we_q;
  assign data_oe       = data_oe_q;
  assign dataoutenable = dataoutenable_q;
  assign busenable     = busenable_q;
  assign rdy           = rdy_q;
  assign diag_halt_ack = ack_q;
  assign viol_count    = viol_q;
  assign state_o       = 3'(state_q);

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios plus randomized CPU
// bus cycles checked against a transaction-level region/protect model and a RAM image.
module tb_ram_bus_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  address;
  logic           phi2, rwbar;
  logic [DW-1:0]  cpu_data_in;
  logic [AW-1:0]  ld_address, diag_address;
  logic [DW-1:0]  ld_data, diag_data;
  logic           ld_cs, ld_we, ld_done;
  logic           diag_halt_req, diag_cs, diag_we;
  logic [NR*AW-1:0] region_base, region_mask;
  logic [NR-1:0]  region_en, region_ro;
  logic [AW-1:0]  ram_address;
  logic [DW-1:0]  ram_datain;
  logic           ram_cs, ram_we, data_oe, dataoutenable, busenable, rdy, diag_halt_ack;
  logic [7:0]     viol_count;
  logic [2:0]     state_o;

  ram_bus_arbiter dut (
    .clk(clk), .reset(reset), .address(address), .phi2(phi2), .rwbar(rwbar),
    .cpu_data_in(cpu_data_in), .ld_address(ld_address), .ld_data(ld_data),
    .ld_cs(ld_cs), .ld_we(ld_we), .ld_done(ld_done), .diag_halt_req(diag_halt_req),
    .diag_address(diag_address), .diag_data(diag_data), .diag_cs(diag_cs), .diag_we(diag_we),
    .region_base(region_base), .region_mask(region_mask), .region_en(region_en),
    .region_ro(region_ro), .ram_address(ram_address), .ram_datain(ram_datain),
    .ram_cs(ram_cs), .ram_we(ram_we), .data_oe(data_oe), .dataoutenable(dataoutenable),
    .busenable(busenable), .rdy(rdy), .diag_halt_ack(diag_halt_ack),
    .viol_count(viol_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int mviol    = 0;
  int w0, win;
  logic [AW-1:0] last_wa;
  logic [DW-1:0] last_wd;
  logic [DW-1:0] mem [0:65535];

  logic           samp_oe, samp_oen, samp_be, samp_cs, samp_we;
  logic [AW-1:0]  samp_addr;
  logic [DW-1:0]  samp_rd;
  logic           rw_r, seen;
  logic [AW-1:0]  a_r, b_r, m_r;
  logic [DW-1:0]  d_r;
  logic [AW-1:0]  mask_pick [5];

  // RAM image and write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (ram_cs && ram_we) begin
      wr_cnt++;
      last_wa = ram_address;
      last_wd = ram_datain;
      mem[ram_address] = ram_datain;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] m,
                            input logic en, input logic ro);
    region_base[i*AW +: AW] = b;
    region_mask[i*AW +: AW] = m;
    region_en[i] = en;
    region_ro[i] = ro;
  endtask

  // Lowest enabled region whose masked compare matches, or -1.
  function automatic int winner(input logic [AW-1:0] a);
    for (int i = 0; i < int'(NR); i++)
      if (region_en[i] && ((a & region_mask[i*AW +: AW]) ==
                           (region_base[i*AW +: AW] & region_mask[i*AW +: AW])))
        return i;
    return -1;
  endfunction

  // One full CPU bus cycle; snapshots the bus late in the phi2-high phase.
  task automatic cpu_cycle(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    address = a; rwbar = rw; cpu_data_in = d;
    clks(2);
    phi2 = 1'b1;
    clks(4);
    samp_oe = data_oe; samp_oen = dataoutenable; samp_be = busenable;
    samp_cs = ram_cs; samp_we = ram_we; samp_addr = ram_address; samp_rd = mem[ram_address];
    phi2 = 1'b0;
    clks(5);
  endtask

  initial begin
    mask_pick[0] = 16'hF000; mask_pick[1] = 16'hC000; mask_pick[2] = 16'h8000;
    mask_pick[3] = 16'hFF00; mask_pick[4] = 16'hE000;
    reset = 1'b1; address = '0; phi2 = 1'b0; rwbar = 1'b1; cpu_data_in = '0;
    ld_address = '0; ld_data = '0; ld_cs = 1'b0; ld_we = 1'b0; ld_done = 1'b0;
    diag_halt_req = 1'b0; diag_address = '0; diag_data = '0; diag_cs = 1'b0; diag_we = 1'b0;
    region_base = '0; region_mask = '0; region_en = '0; region_ro = '0;
    set_region(0, 16'hF000, 16'hF000, 1'b1, 1'b1);
    set_region(1, 16'h0000, 16'h8000, 1'b1, 1'b0);
    clks(3);

    // Reset values
    check_eq("rst_state", state_o, 0);
    check_eq("rst_rdy", rdy, 0);
    check_eq("rst_ack", diag_halt_ack, 0);
    check_eq("rst_oe", data_oe, 0);
    check_eq("rst_oen", dataoutenable, 1);
    check_eq("rst_be", busenable, 1);
    check_eq("rst_cs_we", {ram_cs, ram_we}, 0);
    check_eq("rst_viol", viol_count, 0);
    reset = 1'b0;
    clks(2);

    // Loader owns the RAM during LOAD
    address = 16'h0010;
    ld_address = 16'h1234; ld_data = 8'hA5; ld_cs = 1'b1; ld_we = 1'b1;
    clks(1);
    check_eq("ld_addr", ram_address, 16'h1234);
    check_eq("ld_data", ram_datain, 8'hA5);
    check_eq("ld_cs_we", {ram_cs, ram_we}, 2'b11);
    check_eq("ld_state", state_o, 0);
    ld_cs = 1'b0; ld_we = 1'b0;
    clks(1);
    check_eq("ld_mem", mem[16'h1234], 8'hA5);
    ld_done = 1'b1;
    clks(1);
    check_eq("run_state", state_o, 1);
    check_eq("run_rdy", rdy, 1);

    // Write to protected region is blocked and counted
    w0 = wr_cnt;
    cpu_cycle(1'b0, 16'hF800, 8'h55);
    check_eq("ro_nowrite", wr_cnt - w0, 0);
    check_eq("ro_viol1", viol_count, 1);
    for (int k = 0; k < 300; k++) cpu_cycle(1'b0, 16'hF800, 8'h55);
    check_eq("ro_nowrite300", wr_cnt - w0, 0);
    check_eq("ro_viol_sat", viol_count, 8'hFF);

    // Ordinary write to a RW region
    w0 = wr_cnt;
    cpu_cycle(1'b0, 16'h0010, 8'h3C);
    check_eq("rw_pulses", wr_cnt - w0, 1);
    check_eq("rw_addr", last_wa, 16'h0010);
    check_eq("rw_data", last_wd, 8'h3C);

    // Halt request during a write cycle
    w0 = wr_cnt;
    address = 16'h0030; rwbar = 1'b0; cpu_data_in = 8'h99;
    clks(2); phi2 = 1'b1; clks(2);
    diag_halt_req = 1'b1;
    clks(1);
    check_eq("hp_rdy", rdy, 0);
    check_eq("hp_state", state_o, 2);
    clks(2); phi2 = 1'b0; clks(5);
    check_eq("hp_write_served", wr_cnt - w0, 1);
    check_eq("hp_no_ack", diag_halt_ack, 0);
    cpu_cycle(1'b1, 16'h0010, 8'h00);
    check_eq("halted_ack", diag_halt_ack, 1);
    check_eq("halted_state", state_o, 3);
    check_eq("halted_oe", data_oe, 0);
    check_eq("halted_be", busenable, 1);
    diag_address = 16'h2000; diag_data = 8'h77; diag_cs = 1'b1; diag_we = 1'b1;
    clks(1);
    check_eq("diag_addr", ram_address, 16'h2000);
    check_eq("diag_data", ram_datain, 8'h77);
    check_eq("diag_cs_we", {ram_cs, ram_we}, 2'b11);
    diag_cs = 1'b0; diag_we = 1'b0;
    clks(1);

    // Resume: one idle clock, then RUN
    diag_halt_req = 1'b0;
    clks(1);
    check_eq("resume_state", state_o, 4);
    check_eq("resume_cs", ram_cs, 0);
    check_eq("resume_ack", diag_halt_ack, 0);
    check_eq("resume_rdy", rdy, 0);
    clks(1);
    check_eq("rerun_state", state_o, 1);
    check_eq("rerun_rdy", rdy, 1);
    cpu_cycle(1'b1, 16'h0010, 8'h00);
    check_eq("rd_cs_we", {samp_cs, samp_we}, 2'b10);
    check_eq("rd_addr", samp_addr, 16'h0010);
    check_eq("rd_value", samp_rd, 8'h3C);
    check_eq("rd_oe", samp_oe, 1);
    check_eq("rd_oen", samp_oen, 0);

    // Async reset while HALTED
    diag_halt_req = 1'b1;
    clks(1);
    cpu_cycle(1'b1, 16'h0010, 8'h00);
    check_eq("pre_rst_halted", state_o, 3);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_halted_state", state_o, 0);
    check_eq("rst_halted_ack", diag_halt_ack, 0);
    diag_halt_req = 1'b0; ld_done = 1'b0;
    @(negedge clk) reset = 1'b0;
    clks(2);
    check_eq("reload_state", state_o, 0);
    ld_done = 1'b1;
    clks(1);
    check_eq("reload_run", state_o, 1);

    // Overlapping regions: lowest index (read-only) wins
    set_region(0, 16'h0000, 16'hC000, 1'b1, 1'b1);
    set_region(1, 16'h0000, 16'h8000, 1'b1, 1'b0);
    set_region(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_region(3, 16'h0000, 16'h0000, 1'b0, 1'b0);
    w0 = wr_cnt;
    cpu_cycle(1'b0, 16'h0020, 8'h11);
    check_eq("ovl_nowrite", wr_cnt - w0, 0);
    check_eq("ovl_viol", viol_count, 1);
    mviol = 1;

    // Randomized bus cycles against the region model
    for (int i = 0; i < int'(NR); i++)
      set_region(i, 16'($urandom), mask_pick[$urandom_range(0, 4)],
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    clks(1);
    for (int k = 0; k < 60; k++) begin
      rw_r = 1'($urandom_range(0, 1));
      win  = int'($urandom_range(0, NR - 1));
      b_r  = region_base[win*AW +: AW];
      m_r  = region_mask[win*AW +: AW];
      a_r  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a_r = (b_r & m_r) | (a_r & ~m_r);
      d_r  = 8'($urandom);
      win  = winner(a_r);
      w0   = wr_cnt;
      cpu_cycle(rw_r, a_r, d_r);
      if (!rw_r && win >= 0 && region_ro[win] && mviol != 255) mviol++;
      if (!rw_r && win >= 0 && !region_ro[win]) begin
        check_eq("rnd_wr_cnt", wr_cnt - w0, 1);
        check_eq("rnd_wr_addr", last_wa, a_r);
        check_eq("rnd_wr_data", last_wd, d_r);
      end else begin
        check_eq("rnd_wr_cnt", wr_cnt - w0, 0);
      end
      check_eq("rnd_viol", viol_count, mviol);
      check_eq("rnd_be", samp_be, (win < 0));
      check_eq("rnd_oe", samp_oe, (rw_r && win >= 0));
      check_eq("rnd_rdy", rdy, 1);
    end

    // Reset during an active write pulse clears it at once
    set_region(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_region(1, 16'h0000, 16'h8000, 1'b1, 1'b0);
    set_region(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_region(3, 16'h0000, 16'h0000, 1'b0, 1'b0);
    address = 16'h0040; rwbar = 1'b0; cpu_data_in = 8'h5A;
    clks(2); phi2 = 1'b1; clks(4); phi2 = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      seen = ram_we;
    end
    check_eq("wr_pulse_seen", seen, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_abort_we", ram_we, 0);
    check_eq("rst_abort_cs", ram_cs, 0);
    check_eq("rst_abort_state", state_o, 0);
    @(negedge clk) reset = 1'b0;
    clks(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
